// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment glyphs, checker state encoding and sequence helper
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_GLYPH_0 = 7'h3F;
    localparam seg7_t SEG7_GLYPH_1 = 7'h06;
    localparam seg7_t SEG7_GLYPH_2 = 7'h5B;
    localparam seg7_t SEG7_GLYPH_3 = 7'h4F;
    localparam seg7_t SEG7_GLYPH_4 = 7'h66;
    localparam seg7_t SEG7_GLYPH_5 = 7'h6D;
    localparam seg7_t SEG7_GLYPH_6 = 7'h7D;
    localparam seg7_t SEG7_GLYPH_7 = 7'h07;
    localparam seg7_t SEG7_GLYPH_8 = 7'h7F;
    localparam seg7_t SEG7_GLYPH_9 = 7'h6F;
    localparam seg7_t SEG7_GLYPH_A = 7'h77;
    localparam seg7_t SEG7_GLYPH_B = 7'h7C;
    localparam seg7_t SEG7_GLYPH_C = 7'h39;
    localparam seg7_t SEG7_GLYPH_D = 7'h5E;
    localparam seg7_t SEG7_GLYPH_E = 7'h79;
    localparam seg7_t SEG7_GLYPH_F = 7'h71;
    localparam seg7_t SEG7_BLANK   = 7'h00;

    typedef enum logic {ST_IDLE, ST_LOCKED} seg7_state_t;

    // Successor in the counter's wrapping sequence; anything at or past the top wraps to 0.
    function automatic logic [3:0] seg7_next(input logic [3:0] d, input logic [3:0] max_digit);
        return (d >= max_digit) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// rtl/seg7_pattern_decoder.sv - combinational 7-segment pattern to hex digit decode
module seg7_pattern_decoder
    import seg7_pkg::*;
(
    input  seg7_t       pattern,
    output logic        hit,
    output logic        is_blank,
    output logic [3:0]  digit
);

    always_comb begin
        hit      = 1'b1;
        digit    = 4'h0;
        is_blank = (pattern == SEG7_BLANK);
        case (pattern)
            SEG7_GLYPH_0: digit = 4'h0;
            SEG7_GLYPH_1: digit = 4'h1;
            SEG7_GLYPH_2: digit = 4'h2;
            SEG7_GLYPH_3: digit = 4'h3;
            SEG7_GLYPH_4: digit = 4'h4;
            SEG7_GLYPH_5: digit = 4'h5;
            SEG7_GLYPH_6: digit = 4'h6;
            SEG7_GLYPH_7: digit = 4'h7;
            SEG7_GLYPH_8: digit = 4'h8;
            SEG7_GLYPH_9: digit = 4'h9;
            SEG7_GLYPH_A: digit = 4'hA;
            SEG7_GLYPH_B: digit = 4'hB;
            SEG7_GLYPH_C: digit = 4'hC;
            SEG7_GLYPH_D: digit = 4'hD;
            SEG7_GLYPH_E: digit = 4'hE;
            SEG7_GLYPH_F: digit = 4'hF;
            default:      hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_sequence_checker.sv
// rtl/seg7_sequence_checker.sv - debounced 7-segment digit monitor checking the wrapping count sequence
// SEG7_ACTIVE_LOW_EN: invert seg_in at the synchronizer input for common-anode displays.
module seg7_sequence_checker
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_DIGIT     = 6,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [6:0]           seg_in,
    output logic [3:0]           digit_out,
    output logic                 digit_valid,
    output logic                 invalid_pat,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 locked
);

    localparam logic [7:0]           STABLE_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0]           STABLE_SAT  = 8'(STABLE_CYCLES);
    localparam logic [3:0]           MAX_D       = 4'(MAX_DIGIT);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;

    seg7_t       seg_raw;
    seg7_t       sync1, s, s_prev;
    logic [7:0]  stable_cnt;
    logic        stable_hit;
    logic        dec_hit, dec_blank;
    logic [3:0]  dec_digit;

    seg7_state_t          state, state_d;
    logic [3:0]           expected, expected_d, digit_d;
    logic [ERR_CNT_W-1:0] err_d;
    logic                 dv_d, inv_d, se_d;

`ifdef SEG7_ACTIVE_LOW_EN
    assign seg_raw = ~seg_in;
`else
    assign seg_raw = seg_in;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1      <= '0;
            s          <= '0;
            s_prev     <= '0;
            stable_cnt <= '0;
        end else if (ena) begin
            sync1  <= seg_raw;
            s      <= sync1;
            s_prev <= s;
            if (s != s_prev)
                stable_cnt <= '0;
            else if (stable_cnt != STABLE_SAT)
                stable_cnt <= stable_cnt + 8'd1;
        end
    end

    // Counter saturates past STABLE_LAST, so a held pattern fires exactly once.
    assign stable_hit = (s == s_prev) && (stable_cnt == STABLE_LAST);

    seg7_pattern_decoder u_decoder (
        .pattern  (s),
        .hit      (dec_hit),
        .is_blank (dec_blank),
        .digit    (dec_digit)
    );

    always_comb begin
        state_d    = state;
        expected_d = expected;
        digit_d    = digit_out;
        err_d      = err_cnt;
        dv_d       = 1'b0;
        inv_d      = 1'b0;
        se_d       = 1'b0;
        if (stable_hit && !dec_blank) begin
            if (dec_hit) begin
                digit_d    = dec_digit;
                dv_d       = 1'b1;
                expected_d = seg7_next(dec_digit, MAX_D);
                state_d    = ST_LOCKED;
                if (state == ST_LOCKED && (dec_digit != expected || dec_digit > MAX_D)) begin
                    se_d = 1'b1;
                    if (err_cnt != ERR_MAX)
                        err_d = err_cnt + 1'b1;
                end
            end else begin
                inv_d   = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            expected    <= '0;
            digit_out   <= '0;
            err_cnt     <= '0;
            digit_valid <= 1'b0;
            invalid_pat <= 1'b0;
            seq_err     <= 1'b0;
        end else if (ena) begin
            state       <= state_d;
            expected    <= expected_d;
            digit_out   <= digit_d;
            err_cnt     <= err_d;
            digit_valid <= dv_d;
            invalid_pat <= inv_d;
            seq_err     <= se_d;
        end else begin
            digit_valid <= 1'b0;
            invalid_pat <= 1'b0;
            seq_err     <= 1'b0;
        end
    end

    assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_seg7_sequence_checker.sv
// tb/tb_seg7_sequence_checker.sv - scoreboard bench for seg7_sequence_checker
module tb_seg7_sequence_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [6:0] seg_in = 7'h00;
    logic [3:0] digit_out;
    logic       digit_valid, invalid_pat, seq_err, locked;
    logic [7:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] d;
        logic       dv;
        logic       se;
        logic       inv;
        logic       lk;
        logic [7:0] ec;
    } ev_t;

    ev_t exp_q[$];

    seg7_sequence_checker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .seg_in      (seg_in),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .invalid_pat (invalid_pat),
        .seq_err     (seq_err),
        .err_cnt     (err_cnt),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic dv, input logic se,
                        input logic inv, input logic lk, input logic [7:0] ec);
        ev_t e;
        e.d = d; e.dv = dv; e.se = se; e.inv = inv; e.lk = lk; e.ec = ec;
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic [6:0] p, input int hold);
        @(negedge clk);
        seg_in = p;
        repeat (hold) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        ena    = 1'b1;
        seg_in = 7'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every output pulse must match the next scoreboard entry.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (digit_valid || invalid_pat || seq_err)) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got dv=%0b inv=%0b se=%0b digit=%0h expected no pulse",
                             digit_valid, invalid_pat, seq_err, digit_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_digit_out", 32'(digit_out), 32'(e.d));
                    chk("ev_digit_valid", 32'(digit_valid), 32'(e.dv));
                    chk("ev_seq_err", 32'(seq_err), 32'(e.se));
                    chk("ev_invalid_pat", 32'(invalid_pat), 32'(e.inv));
                    chk("ev_locked", 32'(locked), 32'(e.lk));
                    chk("ev_err_cnt", 32'(err_cnt), 32'(e.ec));
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int pulses;
        // Reset values
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_digit_out", 32'(digit_out), 0);
        chk("rst_digit_valid", 32'(digit_valid), 0);
        chk("rst_invalid_pat", 32'(invalid_pat), 0);
        chk("rst_seq_err", 32'(seq_err), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_locked", 32'(locked), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Latency: 00 -> 06 before edge k, pulse visible after edge k+6 only
        @(negedge clk);
        seg_in = 7'h06;
        push(4'd1, 1, 0, 0, 1, 8'd0);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
            if (i < 7) chk("lat_early", 32'(digit_valid), 0);
            else       chk("lat_edge", 32'(digit_valid), 1);
        end
        repeat (4) @(posedge clk);

        // Full wrapping sequence from reset
        do_reset();
        push(4'd0, 1, 0, 0, 1, 8'd0); apply(7'h3F, 10);
        push(4'd1, 1, 0, 0, 1, 8'd0); apply(7'h06, 10);
        push(4'd2, 1, 0, 0, 1, 8'd0); apply(7'h5B, 10);
        push(4'd3, 1, 0, 0, 1, 8'd0); apply(7'h4F, 10);
        push(4'd4, 1, 0, 0, 1, 8'd0); apply(7'h66, 10);
        push(4'd5, 1, 0, 0, 1, 8'd0); apply(7'h6D, 10);
        push(4'd6, 1, 0, 0, 1, 8'd0); apply(7'h7D, 10);
        push(4'd0, 1, 0, 0, 1, 8'd0); apply(7'h3F, 10);
        #1;
        chk("seq_locked", 32'(locked), 1);
        chk("seq_err_cnt", 32'(err_cnt), 0);

        // Glitch shorter than the stability window
        do_reset();
        @(negedge clk);
        seg_in = 7'h06;
        repeat (2) @(negedge clk);
        seg_in = 7'h00;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_locked", 32'(locked), 0);
        chk("glitch_digit_out", 32'(digit_out), 0);

        // Skip, recovery, invalid pattern, relock
        do_reset();
        push(4'd0, 1, 0, 0, 1, 8'd0); apply(7'h3F, 10);
        push(4'd1, 1, 0, 0, 1, 8'd0); apply(7'h06, 10);
        push(4'd2, 1, 0, 0, 1, 8'd0); apply(7'h5B, 10);
        push(4'd4, 1, 1, 0, 1, 8'd1); apply(7'h66, 10);
        push(4'd5, 1, 0, 0, 1, 8'd1); apply(7'h6D, 10);
        push(4'd5, 0, 0, 1, 0, 8'd1); apply(7'h55, 10);
        #1;
        chk("inv_locked", 32'(locked), 0);
        chk("inv_digit_out", 32'(digit_out), 5);
        push(4'd0, 1, 0, 0, 1, 8'd1); apply(7'h3F, 10);

        // Saturation of the error counter
        do_reset();
        push(4'd0, 1, 0, 0, 1, 8'd0); apply(7'h3F, 8);
        for (int i = 0; i < 260; i++) begin
            push((i % 2 == 0) ? 4'd3 : 4'd0, 1, 1, 0, 1, (i + 1 > 255) ? 8'hFF : 8'(i + 1));
            apply((i % 2 == 0) ? 7'h4F : 7'h3F, 7);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("sat_err_cnt", 32'(err_cnt), 32'hFF);

        // ena dropped mid-stable period
        do_reset();
        push(4'd0, 1, 0, 0, 1, 8'd0); apply(7'h3F, 10);
        @(negedge clk);
        seg_in = 7'h06;
        push(4'd1, 1, 0, 0, 1, 8'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        ena = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (digit_valid || invalid_pat || seq_err) pulses++;
        end
        chk("ena_low_pulses", 32'(pulses), 0);
        @(negedge clk);
        ena = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            chk("ena_resume_dv", 32'(digit_valid), (i == 3) ? 32'd1 : 32'd0);
        end

        repeat (10) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
